// File: rtl/pixie_raster_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : pixie_raster_scanout
//  Purpose  : 1-bpp raster scan-out engine. It generates the raster timing,
//             fetches one frame-buffer byte per 8 pixels from a synchronous
//             RAM and shifts the pixels out MSB first.
//  Revision : 1.0  initial release
// ============================================================================
module pixie_raster_scanout #(
    parameter int H_TOTAL     = 112,
    parameter int V_TOTAL     = 262,
    parameter int H_ACT_START = 16,
    parameter int V_ACT_START = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       enable,
    output logic [9:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_data,
    output logic       video,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       de
);

    localparam logic [9:0] c_H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT_START = 10'(H_ACT_START);
    localparam logic [9:0] c_H_ACT_END   = 10'(H_ACT_START + 63);
    localparam logic [9:0] c_V_ACT_START = 10'(V_ACT_START);
    localparam logic [9:0] c_V_ACT_END   = 10'(V_ACT_START + 127);
    // A fetch is issued three pixels ahead of the byte it feeds: one clk for
    // the RAM, one clk to capture into the hold register, then the load.
    localparam logic [9:0] c_RD_START    = 10'(H_ACT_START - 3);
    localparam logic [9:0] c_HS_START    = 10'd92;
    localparam logic [9:0] c_HS_END      = 10'd99;
    localparam logic [9:0] c_VS_END      = 10'd3;

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_fresh;       // first pix_ce after reset starts the frame at 0,0
    logic       r_frame_en;
    logic [9:0] r_addr;
    logic       r_rd_en;
    logic       r_rd_dly;      // RAM data is valid while this is high
    logic [7:0] r_hold;
    logic [7:0] r_shift;
    logic       r_video;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_hblank;
    logic       r_vblank;
    logic       r_de;

    logic [9:0] w_hnext;
    logic [9:0] w_vnext;
    logic       w_frame_start;
    logic       w_frame_en_next;
    logic       w_h_act;
    logic       w_v_act;
    logic [9:0] w_h_off;
    logic [9:0] w_rd_off;
    logic       w_pix_load;
    logic       w_rd_hit;
    logic       w_de_next;
    logic       w_pix;

    // Next counter values and everything decoded from them.
    always_comb begin
        w_hnext = r_hcount;
        w_vnext = r_vcount;
        if (r_fresh) begin
            w_hnext = '0;
            w_vnext = '0;
        end else if (r_hcount == c_H_LAST) begin
            w_hnext = '0;
            w_vnext = (r_vcount == c_V_LAST) ? 10'd0 : r_vcount + 10'd1;
        end else begin
            w_hnext = r_hcount + 10'd1;
        end

        w_frame_start   = (w_hnext == 10'd0) && (w_vnext == 10'd0);
        w_frame_en_next = w_frame_start ? enable : r_frame_en;

        w_h_act = (w_hnext >= c_H_ACT_START) && (w_hnext <= c_H_ACT_END);
        w_v_act = (w_vnext >= c_V_ACT_START) && (w_vnext <= c_V_ACT_END);

        w_h_off    = w_hnext - c_H_ACT_START;
        w_pix_load = w_h_act && (w_h_off[2:0] == 3'd0);

        // Out-of-range columns wrap to large unsigned offsets and miss.
        w_rd_off = w_hnext - c_RD_START;
        w_rd_hit = (w_rd_off < 10'd64) && (w_rd_off[2:0] == 3'd0)
                   && w_v_act && w_frame_en_next;

        w_de_next = w_frame_en_next && w_h_act && w_v_act;
        w_pix     = w_pix_load ? r_hold[7] : r_shift[6];
    end

    // Raster counters, frame enable latch and registered video outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount   <= '0;
            r_vcount   <= '0;
            r_fresh    <= 1'b1;
            r_frame_en <= 1'b0;
            r_shift    <= '0;
            r_video    <= 1'b0;
            r_hsync    <= 1'b0;
            r_vsync    <= 1'b0;
            r_hblank   <= 1'b1;
            r_vblank   <= 1'b1;
            r_de       <= 1'b0;
        end else if (pix_ce) begin
            r_hcount   <= w_hnext;
            r_vcount   <= w_vnext;
            r_fresh    <= 1'b0;
            r_frame_en <= w_frame_en_next;
            r_shift    <= w_pix_load ? r_hold : {r_shift[6:0], 1'b0};
            r_video    <= w_de_next && w_pix;
            r_hsync    <= (w_hnext >= c_HS_START) && (w_hnext <= c_HS_END);
            r_vsync    <= (w_vnext <= c_VS_END);
            r_hblank   <= !w_h_act;
            r_vblank   <= !w_v_act;
            r_de       <= w_de_next;
        end
    end

    // Fetch side: single-clk read strobe, address counter, data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_rd_en  <= 1'b0;
            r_rd_dly <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_rd_en  <= pix_ce && w_rd_hit;
            r_rd_dly <= r_rd_en;
            if (r_rd_dly) begin
                r_hold <= mem_data;
            end
            if (pix_ce && w_frame_start) begin
                r_addr <= '0;
            end else if (r_rd_en) begin
                r_addr <= r_addr + 10'd1;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_rd_en = r_rd_en;
    assign video     = r_video;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign hblank    = r_hblank;
    assign vblank    = r_vblank;
    assign de        = r_de;

endmodule
`default_nettype wire

// File: tb/tb_pixie_raster_scanout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pixie_raster_scanout
//  Purpose  : Directed self-checking bench for pixie_raster_scanout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixie_raster_scanout;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce;
    logic       enable;
    logic [9:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_data;
    logic       video, hsync, vsync, hblank, vblank, de;

    pixie_raster_scanout dut (
        .clk       (clk),
        .reset     (reset),
        .pix_ce    (pix_ce),
        .enable    (enable),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_data  (mem_data),
        .video     (video),
        .hsync     (hsync),
        .vsync     (vsync),
        .hblank    (hblank),
        .vblank    (vblank),
        .de        (de)
    );

    always #5 clk = ~clk;

    // Synchronous frame-buffer RAM.
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_rd_en) mem_data <= ram[mem_addr];
    end

    int n_chk = 0;
    int n_bad = 0;

    // Raster model and running error tallies.
    int   mh, mv;
    bit   started, mfe, prev_rd;
    int   rd_err, sync_err, vid_err, blank_err, width_err;
    int   reads, lit, rd_cnt80;
    int   rd_pos [8];
    logic [15:0] vid_cap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic observe(input bit ce);
        bit   h_act, v_act, exp_de, exp_hs, exp_vs, rd_slot;
        logic exp_v;
        int   a;
        h_act   = (mh >= 16) && (mh <= 79);
        v_act   = (mv >= 80) && (mv <= 207);
        exp_de  = mfe && h_act && v_act;
        exp_hs  = (mh >= 92) && (mh <= 99);
        exp_vs  = (mv <= 3);
        rd_slot = mfe && v_act && (mh >= 13) && (mh <= 69) && ((mh - 13) % 8 == 0);
        if (hblank !== !h_act || vblank !== !v_act || de !== exp_de) blank_err++;
        if (hsync !== exp_hs || vsync !== exp_vs) sync_err++;
        if (de === 1'b1 && (hsync === 1'b1 || vsync === 1'b1)) sync_err++;
        exp_v = 1'b0;
        if (exp_de) begin
            a     = (mv - 80) * 8 + (mh - 16) / 8;
            exp_v = ram[a][7 - ((mh - 16) % 8)];
        end
        if (video !== exp_v) vid_err++;
        if (ce && video === 1'b1) lit++;
        if (mem_rd_en === 1'b1) begin
            reads++;
            if (prev_rd) width_err++;
            if (!(ce && rd_slot && mem_addr == 10'((mv - 80) * 8 + (mh - 13) / 8))) rd_err++;
            if (mv == 80) begin
                if (rd_cnt80 < 8) rd_pos[rd_cnt80] = mh;
                rd_cnt80++;
            end
        end else if (ce && rd_slot) begin
            rd_err++;
        end
        prev_rd = (mem_rd_en === 1'b1);
        if (ce && mv == 80 && mh >= 16 && mh <= 31) vid_cap[31 - mh] = video;
    endtask

    task automatic step(input bit ce);
        pix_ce = ce;
        @(posedge clk);
        #1;
        if (ce && !reset) begin
            if (!started) begin
                mh = 0; mv = 0; started = 1'b1; mfe = enable;
            end else begin
                if (mh == 111) begin
                    mh = 0;
                    mv = (mv == 261) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
                if (mh == 0 && mv == 0) mfe = enable;
            end
        end
        if (started && !reset) observe(ce);
    endtask

    // Step until the model reaches (tv,th) on a pix_ce edge; pix_ce is 1-in-div.
    task automatic run_until(input int tv, input int th, input int div);
        int ph, guard;
        bit ce;
        ph = 0; guard = 0;
        do begin
            ce = (ph == 0);
            ph = (ph + 1) % div;
            step(ce);
            guard++;
        end while (!(ce && started && mh == th && mv == tv) && guard < 70000);
        if (guard >= 70000) chk("run_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_video"},  video,     1'b0);
        chk({tag, "_hsync"},  hsync,     1'b0);
        chk({tag, "_de"},     de,        1'b0);
        chk({tag, "_rd_en"},  mem_rd_en, 1'b0);
        chk({tag, "_hblank"}, hblank,    1'b1);
        chk({tag, "_vblank"}, vblank,    1'b1);
        chk({tag, "_addr"},   mem_addr,  10'd0);
    endtask

    task automatic chk_line80(input string tag);
        chk({tag, "_nreads"}, rd_cnt80, 8);
        chk({tag, "_rd0_h"},  rd_pos[0], 13);
        chk({tag, "_rd7_h"},  rd_pos[7], 69);
        chk({tag, "_pix16_31"}, vid_cap, 16'h0001);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pix_ce = 1'b0;
        started = 1'b0; mfe = 1'b0; prev_rd = 1'b0; mh = 0; mv = 0;
        rd_err = 0; sync_err = 0; vid_err = 0; blank_err = 0; width_err = 0;
        reads = 0; lit = 0; rd_cnt80 = 0; vid_cap = '0;
        for (int i = 0; i < 8; i++) rd_pos[i] = -1;
        for (int i = 0; i < 1024; i++) ram[i] = (i < 8) ? 8'(i) : 8'hA5;

        // Reset applies with or without pix_ce.
        step(1'b1); step(1'b0); step(1'b1);
        chk_reset_outputs("por");
        reset = 1'b0;

        // Frame 0: display off, enable raised mid-frame at line 100.
        run_until(100, 0, 1);
        enable = 1'b1;
        run_until(0, 0, 1);
        chk("f0_reads", reads, 0);
        chk("f0_lit",   lit,   0);
        chk("f1_start_addr", mem_addr, 10'd0);
        reads = 0; lit = 0; rd_cnt80 = 0; vid_cap = '0;
        for (int i = 0; i < 8; i++) rd_pos[i] = -1;

        // Frame 1: full display with pix_ce continuous.
        run_until(81, 0, 1);
        chk_line80("ce1");
        run_until(0, 0, 1);
        chk("f1_reads", reads, 1024);
        chk("f1_lit",   lit,   4076);
        chk("f2_start_addr", mem_addr, 10'd0);

        // Frame 2: line 80 scanned with pix_ce at 1-in-3.
        run_until(79, 100, 1);
        rd_cnt80 = 0; vid_cap = '0;
        for (int i = 0; i < 8; i++) rd_pos[i] = -1;
        run_until(81, 0, 3);
        chk_line80("ce3");
        chk("ce3_rd_width", width_err, 0);

        // Mid-frame reset at line 120, column 40, held for two clks.
        run_until(120, 40, 1);
        reset = 1'b1; started = 1'b0; prev_rd = 1'b0; mfe = 1'b0;
        step(1'b0); step(1'b1);
        chk_reset_outputs("mid");
        reset = 1'b0;
        run_until(0, 0, 1);
        chk("restart_vsync",  vsync,    1'b1);
        chk("restart_hblank", hblank,   1'b1);
        chk("restart_addr",   mem_addr, 10'd0);
        run_until(2, 0, 1);

        chk("blank_errors", blank_err, 0);
        chk("sync_errors",  sync_err,  0);
        chk("video_errors", vid_err,   0);
        chk("read_errors",  rd_err,    0);
        chk("width_errors", width_err, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
